// File: rtl/audio_mixer_if.sv
// audio_mixer bus: sample strobe, speaker bit and Mockingboard samples in,
// mixed 16-bit L/R samples, valid pulse and sticky overrun flag out.
interface audio_mixer_if;
   logic        sample_strobe_i;
   logic        speaker_bit_i;
   logic [9:0]  mb_audio_l_i;
   logic [9:0]  mb_audio_r_i;
   logic [15:0] audio_l_o;
   logic [15:0] audio_r_o;
   logic        valid_o;
   logic        overrun_o;

   modport master (
      output sample_strobe_i, speaker_bit_i,
      output mb_audio_l_i, mb_audio_r_i,
      input  audio_l_o, audio_r_o, valid_o, overrun_o
   );

   modport slave (
      input  sample_strobe_i, speaker_bit_i,
      input  mb_audio_l_i, mb_audio_r_i,
      output audio_l_o, audio_r_o, valid_o, overrun_o
   );
endinterface

// File: rtl/audio_mixer.sv
// Speaker/Mockingboard mixer with saturation and optional 4-tap box-car.
// Ports: clk_pixel, reset (sync, active-high), bus (audio_mixer_if.slave).
module audio_mixer #(
   parameter bit          SPEAKER_ENABLE = 1'b0,
   parameter logic [15:0] SPEAKER_LEVEL  = 16'h2000,
   parameter logic [7:0]  HOLD_SAMPLES   = 8'd255,
   parameter int          MB_SHIFT       = 5,
   parameter bit          FILTER_EN      = 1'b1
) (
   input logic         clk_pixel,
   input logic         reset,
   audio_mixer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MIX_L, MIX_R, OUT} state_t;

   state_t             state;
   logic               spk_m;
   logic               spk_s;
   logic               spk_d;
   logic               spk_edge;
   logic               edge_pend;
   logic               spk_lvl;
   logic [7:0]         hold_cnt;
   logic [9:0]         cap_l;
   logic [9:0]         cap_r;
   logic [3:0][15:0]   hist_l;
   logic [3:0][15:0]   hist_r;
   logic [17:0]        sum_l;
   logic [17:0]        sum_r;

   assign spk_edge = spk_s ^ spk_d;

   // 17-bit sum so a carry out clamps to full scale instead of wrapping
   function automatic logic [15:0] mix(input logic [9:0] mb,
                                       input logic lvl);
      logic [15:0] mb_sh;
      logic [16:0] acc;
      mb_sh = {6'b0, mb} << MB_SHIFT;
      acc   = {1'b0, mb_sh} + (lvl ? {1'b0, SPEAKER_LEVEL} : 17'd0);
      return acc[16] ? 16'hFFFF : acc[15:0];
   endfunction

   always_comb begin
      sum_l = 18'(hist_l[0]) + 18'(hist_l[1])
            + 18'(hist_l[2]) + 18'(hist_l[3]);
      sum_r = 18'(hist_r[0]) + 18'(hist_r[1])
            + 18'(hist_r[2]) + 18'(hist_r[3]);
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state         <= IDLE;
         spk_m         <= 1'b0;
         spk_s         <= 1'b0;
         spk_d         <= 1'b0;
         edge_pend     <= 1'b0;
         spk_lvl       <= 1'b0;
         hold_cnt      <= 8'd0;
         cap_l         <= 10'd0;
         cap_r         <= 10'd0;
         hist_l        <= '0;
         hist_r        <= '0;
         bus.audio_l_o <= 16'd0;
         bus.audio_r_o <= 16'd0;
         bus.valid_o   <= 1'b0;
         bus.overrun_o <= 1'b0;
      end else begin
         spk_m       <= bus.speaker_bit_i;
         spk_s       <= spk_m;
         spk_d       <= spk_s;
         bus.valid_o <= 1'b0;
         if (spk_edge)
            edge_pend <= 1'b1;
         if (bus.sample_strobe_i && state != IDLE)
            bus.overrun_o <= 1'b1;
         unique case (state)
            IDLE: begin
               if (bus.sample_strobe_i) begin
                  cap_l   <= bus.mb_audio_l_i;
                  cap_r   <= bus.mb_audio_r_i;
                  spk_lvl <= SPEAKER_ENABLE && spk_s
                             && (edge_pend || hold_cnt != 8'd0);
                  if (edge_pend || spk_edge)
                     hold_cnt <= HOLD_SAMPLES;
                  else if (hold_cnt != 8'd0)
                     hold_cnt <= hold_cnt - 8'd1;
                  // an edge in this same cycle is consumed by the reload
                  edge_pend <= 1'b0;
                  state     <= MIX_L;
               end
            end
            MIX_L: begin
               hist_l <= {hist_l[2:0], mix(cap_l, spk_lvl)};
               state  <= MIX_R;
            end
            MIX_R: begin
               hist_r <= {hist_r[2:0], mix(cap_r, spk_lvl)};
               state  <= OUT;
            end
            OUT: begin
               bus.audio_l_o <= FILTER_EN ? sum_l[17:2] : hist_l[0];
               bus.audio_r_o <= FILTER_EN ? sum_r[17:2] : hist_r[0];
               bus.valid_o   <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: three parameter sets driven from one
// clock, expected samples queued at strobe time, popped on valid_o.
module tb_audio_mixer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   audio_mixer_if a ();
   audio_mixer_if b ();
   audio_mixer_if c ();

   audio_mixer #(
      .SPEAKER_ENABLE(1'b0), .FILTER_EN(1'b1), .MB_SHIFT(5)
   ) u_a (.clk_pixel(clk), .reset(rst), .bus(a));

   audio_mixer #(
      .SPEAKER_ENABLE(1'b1), .FILTER_EN(1'b0), .MB_SHIFT(5)
   ) u_b (.clk_pixel(clk), .reset(rst), .bus(b));

   audio_mixer #(
      .SPEAKER_ENABLE(1'b1), .FILTER_EN(1'b0), .MB_SHIFT(6)
   ) u_c (.clk_pixel(clk), .reset(rst), .bus(c));

   typedef struct {
      int l;
      int r;
      int due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   exp_t ea, eb, ec;
   int   n_chk = 0;
   int   n_pass = 0;
   int   hl[4];
   int   hr[4];

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   always @(posedge clk) begin
      #1;
      if (a.valid_o) begin
         check("a_expected", int'(qa.size() > 0), 1);
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            check("a_l", int'(a.audio_l_o), ea.l);
            check("a_r", int'(a.audio_r_o), ea.r);
            check("a_lat", cyc, ea.due);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (b.valid_o) begin
         check("b_expected", int'(qb.size() > 0), 1);
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            check("b_l", int'(b.audio_l_o), eb.l);
            check("b_r", int'(b.audio_r_o), eb.r);
            check("b_lat", cyc, eb.due);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (c.valid_o) begin
         check("c_expected", int'(qc.size() > 0), 1);
         if (qc.size() > 0) begin
            ec = qc.pop_front();
            check("c_l", int'(c.audio_l_o), ec.l);
            check("c_r", int'(c.audio_r_o), ec.r);
            check("c_lat", cyc, ec.due);
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         hl[i] = 0;
         hr[i] = 0;
      end
   endtask

   task automatic model_a(input int l, input int r,
                          output int el, output int er);
      for (int i = 3; i > 0; i--) begin
         hl[i] = hl[i-1];
         hr[i] = hr[i-1];
      end
      hl[0] = l * 32;
      hr[0] = r * 32;
      el = (hl[0] + hl[1] + hl[2] + hl[3]) / 4;
      er = (hr[0] + hr[1] + hr[2] + hr[3]) / 4;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int d, input bit push,
                        input int el, input int er);
      exp_t e;
      @(negedge clk);
      e.l   = el;
      e.r   = er;
      e.due = cyc + 4;
      case (d)
         0: begin
            a.sample_strobe_i = 1'b1;
            if (push) qa.push_back(e);
         end
         1: begin
            b.sample_strobe_i = 1'b1;
            if (push) qb.push_back(e);
         end
         default: begin
            c.sample_strobe_i = 1'b1;
            if (push) qc.push_back(e);
         end
      endcase
      @(negedge clk);
      a.sample_strobe_i = 1'b0;
      b.sample_strobe_i = 1'b0;
      c.sample_strobe_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (qa.size() + qb.size() + qc.size() == 0) break;
         @(negedge clk);
      end
      check(tag, qa.size() + qb.size() + qc.size(), 0);
   endtask

   initial begin
      int el, er;
      a.sample_strobe_i = 1'b0;
      b.sample_strobe_i = 1'b0;
      c.sample_strobe_i = 1'b0;
      a.speaker_bit_i   = 1'b0;
      b.speaker_bit_i   = 1'b0;
      c.speaker_bit_i   = 1'b0;
      a.mb_audio_l_i    = 10'd0;
      a.mb_audio_r_i    = 10'd0;
      b.mb_audio_l_i    = 10'd0;
      b.mb_audio_r_i    = 10'd0;
      c.mb_audio_l_i    = 10'd0;
      c.mb_audio_r_i    = 10'd0;
      model_clear();

      // reset values
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(10);
      check("rst_a_l", int'(a.audio_l_o), 0);
      check("rst_a_r", int'(a.audio_r_o), 0);
      check("rst_a_valid", int'(a.valid_o), 0);
      check("rst_a_ovr", int'(a.overrun_o), 0);
      check("rst_b_l", int'(b.audio_l_o), 0);
      check("rst_c_r", int'(c.audio_r_o), 0);

      // filter ramp
      a.mb_audio_l_i = 10'd1023;
      a.mb_audio_r_i = 10'd1023;
      for (int i = 0; i < 4; i++) begin
         model_a(1023, 1023, el, er);
         pulse(0, 1'b1, el, er);
         idle(598);
      end
      drain("ramp_drain");
      check("ramp_final", int'(a.audio_l_o), 32736);

      // overrun: second strobe 2 cycles later is dropped
      do_reset();
      a.mb_audio_l_i = 10'd100;
      a.mb_audio_r_i = 10'd200;
      model_a(100, 200, el, er);
      pulse(0, 1'b1, el, er);
      pulse(0, 1'b0, 0, 0);
      drain("ovr_drain");
      check("ovr_set", int'(a.overrun_o), 1);
      idle(20);
      check("ovr_sticky", int'(a.overrun_o), 1);
      do_reset();
      check("ovr_clr", int'(a.overrun_o), 0);

      // strobe exactly 4 cycles later is accepted
      model_a(100, 200, el, er);
      pulse(0, 1'b1, el, er);
      idle(2);
      a.mb_audio_l_i = 10'd7;
      a.mb_audio_r_i = 10'd900;
      model_a(7, 900, el, er);
      pulse(0, 1'b1, el, er);
      drain("t4_drain");
      check("t4_no_ovr", int'(a.overrun_o), 0);

      // reset mid-operation
      do_reset();
      pulse(0, 1'b0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      idle(10);
      check("mid_l", int'(a.audio_l_o), 0);
      check("mid_r", int'(a.audio_r_o), 0);
      a.mb_audio_l_i = 10'd1023;
      a.mb_audio_r_i = 10'd1023;
      model_a(1023, 1023, el, er);
      pulse(0, 1'b1, el, er);
      drain("mid_drain");

      // speaker hold timeout
      b.speaker_bit_i = 1'b1;
      idle(10);
      for (int i = 0; i < 260; i++) begin
         pulse(1, 1'b1, (i < 256) ? 8192 : 0, (i < 256) ? 8192 : 0);
         idle(4);
      end
      b.speaker_bit_i = 1'b0;
      idle(10);
      pulse(1, 1'b1, 0, 0);
      idle(4);
      pulse(1, 1'b1, 0, 0);
      idle(4);
      b.speaker_bit_i = 1'b1;
      idle(10);
      pulse(1, 1'b1, 8192, 8192);
      drain("spk_drain");

      // saturation
      c.mb_audio_l_i = 10'd1023;
      c.mb_audio_r_i = 10'd1023;
      pulse(2, 1'b1, 65472, 65472);
      idle(4);
      c.speaker_bit_i = 1'b1;
      idle(10);
      pulse(2, 1'b1, 65535, 65535);
      drain("sat_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
